// File: rtl/garo_trng_collector.sv
`default_nettype none
// ============================================================================
// Module   : garo_trng_collector
// Purpose  : GARO entropy collector: sync, decimate, XOR-combine, debias,
//            repetition health test, word packing with valid/ready output.
// Revision : 1.0
// ============================================================================
module garo_trng_collector #(
  parameter int NUM_CH     = 4,
  parameter int WORD_W     = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int DEBIAS     = 1,
  parameter int REP_LIMIT  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] osc_i,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              overrun,
  output logic              health_fail
);

  localparam int         c_bc_w      = $clog2(WORD_W + 1);
  localparam logic [7:0] c_div_last  = 8'(SAMPLE_DIV - 1);
  localparam logic [7:0] c_rep_limit = 8'(REP_LIMIT);
  localparam logic [c_bc_w-1:0] c_word_last = c_bc_w'(WORD_W - 1);

  logic [NUM_CH-1:0] r_sync1, r_sync_q;
  logic [7:0]        r_div_cnt;
  logic              r_have_first, r_first_bit;
  logic              r_emit, r_emit_bit;
  logic [7:0]        r_rep_cnt;
  logic              r_last_bit;
  logic [WORD_W-1:0] r_shift;
  logic [c_bc_w-1:0] r_bit_cnt;

  logic              w_samp_stb, w_samp_bit;
  logic [7:0]        w_rep_next;
  logic              w_trip, w_fail, w_done, w_load, w_drop;
  logic [WORD_W-1:0] w_word;

  assign w_samp_stb = enable && (r_div_cnt == c_div_last);
  assign w_samp_bit = ^(r_sync_q & ch_mask);

  // Two-flop synchronisers stay live regardless of enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= '0;
      r_sync_q <= '0;
    end else begin
      r_sync1  <= osc_i;
      r_sync_q <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
    end else if (!enable || w_samp_stb) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

  // Pair state and registered emit; for 01/10 the emitted bit equals the first bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_have_first <= 1'b0;
      r_first_bit  <= 1'b0;
      r_emit       <= 1'b0;
      r_emit_bit   <= 1'b0;
    end else if (!enable) begin
      r_have_first <= 1'b0;
      r_first_bit  <= 1'b0;
      r_emit       <= 1'b0;
      r_emit_bit   <= 1'b0;
    end else begin
      r_emit <= 1'b0;
      if (w_samp_stb) begin
        if (DEBIAS == 0) begin
          r_emit     <= 1'b1;
          r_emit_bit <= w_samp_bit;
        end else if (!r_have_first) begin
          r_have_first <= 1'b1;
          r_first_bit  <= w_samp_bit;
        end else begin
          r_have_first <= 1'b0;
          r_emit       <= r_first_bit ^ w_samp_bit;
          r_emit_bit   <= r_first_bit;
        end
      end
    end
  end

  always_comb begin
    w_rep_next = 8'd1;
    if (r_rep_cnt != 8'd0 && r_emit_bit == r_last_bit) begin
      w_rep_next = (r_rep_cnt == c_rep_limit) ? r_rep_cnt : r_rep_cnt + 8'd1;
    end
  end

  // The word finished by the tripping bit is withheld along with all later ones.
  assign w_trip = r_emit && (w_rep_next == c_rep_limit);
  assign w_fail = health_fail || w_trip;
  assign w_word = {r_shift[WORD_W-2:0], r_emit_bit};
  assign w_done = r_emit && (r_bit_cnt == c_word_last);
  assign w_load = w_done && !w_fail && (!rnd_valid || rnd_ready);
  assign w_drop = w_done && !w_fail && rnd_valid && !rnd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rep_cnt   <= '0;
      r_last_bit  <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      overrun     <= 1'b0;
      health_fail <= 1'b0;
    end else if (!enable) begin
      r_rep_cnt   <= '0;
      r_last_bit  <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      overrun     <= 1'b0;
      health_fail <= 1'b0;
    end else if (r_emit) begin
      r_rep_cnt   <= w_rep_next;
      r_last_bit  <= r_emit_bit;
      r_shift     <= w_word;
      r_bit_cnt   <= w_done ? '0 : r_bit_cnt + 1'b1;
      overrun     <= overrun | w_drop;
      health_fail <= health_fail | w_trip;
    end
  end

  // Holding register ignores enable so a pending word can still drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
    end else if (w_load) begin
      rnd_data  <= w_word;
      rnd_valid <= 1'b1;
    end else if (rnd_valid && rnd_ready) begin
      rnd_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_garo_trng_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_garo_trng_collector
// Purpose  : Scoreboard bench for three collector configurations.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_garo_trng_collector;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] osc;
  // A: 1 ch, 8-bit words, every clock, no debias
  logic en_a, rdy_a, val_a, ovr_a, hf_a;
  logic [0:0] mask_a;
  logic [7:0] data_a;
  // B: 4 ch, 8-bit words, every clock, debias
  logic en_b, rdy_b, val_b, ovr_b, hf_b;
  logic [3:0] mask_b;
  logic [7:0] data_b;
  // C: 2 ch, 4-bit words, divide by 3, no debias
  logic en_c, rdy_c, val_c, ovr_c, hf_c;
  logic [1:0] mask_c;
  logic [3:0] data_c;

  garo_trng_collector #(.NUM_CH(1), .WORD_W(8), .SAMPLE_DIV(1), .DEBIAS(0), .REP_LIMIT(32)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .ch_mask(mask_a), .osc_i(osc[0:0]),
    .rnd_data(data_a), .rnd_valid(val_a), .rnd_ready(rdy_a), .overrun(ovr_a), .health_fail(hf_a));
  garo_trng_collector #(.NUM_CH(4), .WORD_W(8), .SAMPLE_DIV(1), .DEBIAS(1), .REP_LIMIT(32)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .ch_mask(mask_b), .osc_i(osc),
    .rnd_data(data_b), .rnd_valid(val_b), .rnd_ready(rdy_b), .overrun(ovr_b), .health_fail(hf_b));
  garo_trng_collector #(.NUM_CH(2), .WORD_W(4), .SAMPLE_DIV(3), .DEBIAS(0), .REP_LIMIT(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .enable(en_c), .ch_mask(mask_c), .osc_i(osc[1:0]),
    .rnd_data(data_c), .rnd_valid(val_c), .rnd_ready(rdy_c), .overrun(ovr_c), .health_fail(hf_c));

  int n_cmp = 0, n_err = 0;
  int got_a = 0, got_b = 0, got_c = 0;
  logic [7:0] q_a[$], q_b[$];
  logic [3:0] q_c[$];
  logic [7:0] exp_a, exp_b;
  logic [3:0] exp_c;

  // Scoreboards: a word transfers on the next rising edge when valid & ready.
  always begin
    @(negedge clk); #3;
    if (val_a && rdy_a) begin
      got_a++; n_cmp++;
      exp_a = (q_a.size() > 0) ? q_a.pop_front() : 8'hxx;
      if (data_a !== exp_a) begin n_err++; $display("FAIL word_a: got %h expected %h", data_a, exp_a); end
    end
    if (val_b && rdy_b) begin
      got_b++; n_cmp++;
      exp_b = (q_b.size() > 0) ? q_b.pop_front() : 8'hxx;
      if (data_b !== exp_b) begin n_err++; $display("FAIL word_b: got %h expected %h", data_b, exp_b); end
    end
    if (val_c && rdy_c) begin
      got_c++; n_cmp++;
      exp_c = (q_c.size() > 0) ? q_c.pop_front() : 4'hx;
      if (data_c !== exp_c) begin n_err++; $display("FAIL word_c: got %h expected %h", data_c, exp_c); end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Samples taken on edges 2..9 see w MSB first through the synchroniser.
  task automatic drive_a(input logic [7:0] w, input bit push);
    if (push) q_a.push_back(w);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      osc[0] = (n < 8) ? w[7-n] : 1'b0;
      en_a   = (n >= 2);
    end
    @(negedge clk);
    en_a = 1'b0; osc[0] = 1'b0;
  endtask

  task automatic test_reset;
    tick(3); #3;
    n_cmp++; if ({val_a, ovr_a, hf_a, data_a} !== 11'd0) begin n_err++; $display("FAIL reset_a: got %b expected 0", {val_a, ovr_a, hf_a, data_a}); end
    n_cmp++; if ({val_b, ovr_b, hf_b, data_b} !== 11'd0) begin n_err++; $display("FAIL reset_b: got %b expected 0", {val_b, ovr_b, hf_b, data_b}); end
    n_cmp++; if ({val_c, ovr_c, hf_c, data_c} !== 7'd0) begin n_err++; $display("FAIL reset_c: got %b expected 0", {val_c, ovr_c, hf_c, data_c}); end
    @(negedge clk); reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_word_a(input logic [7:0] w);
    int g0;
    g0 = got_a; rdy_a = 1'b1; mask_a = 1'b1;
    drive_a(w, 1'b1);
    tick(3); #3;
    n_cmp++; if (got_a - g0 !== 1) begin n_err++; $display("FAIL pulses_%h: got %0d expected 1", w, got_a - g0); end
    n_cmp++; if (q_a.size() !== 0) begin n_err++; $display("FAIL pending_%h: got %0d expected 0", w, q_a.size()); end
    n_cmp++; if (val_a !== 1'b0) begin n_err++; $display("FAIL idle_%h: got %b expected 0", w, val_a); end
  endtask

  task automatic test_overrun;
    logic [7:0] w1, w2;
    w1 = 8'hA5; w2 = 8'h3C;
    rdy_a = 1'b0; mask_a = 1'b1;
    q_a.push_back(w1);
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      osc[0] = (n < 8) ? w1[7-n] : (n < 16) ? w2[15-n] : 1'b0;
      en_a   = (n >= 2);
      if (n == 20) rdy_a = 1'b1;
      #3;
      if (n >= 12) begin
        n_cmp++;
        if (val_a !== 1'b1 || data_a !== w1) begin n_err++; $display("FAIL hold_%0d: got %b/%h expected 1/%h", n, val_a, data_a, w1); end
      end
      if (n == 20) begin
        n_cmp++; if (ovr_a !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b expected 1", ovr_a); end
      end
    end
    @(negedge clk); rdy_a = 1'b0; en_a = 1'b0; osc[0] = 1'b0; #3;
    n_cmp++; if (val_a !== 1'b0) begin n_err++; $display("FAIL drained: got %b expected 0", val_a); end
    n_cmp++; if (q_a.size() !== 0) begin n_err++; $display("FAIL overrun_pending: got %0d expected 0", q_a.size()); end
    @(negedge clk); #3;
    n_cmp++; if (ovr_a !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b expected 0", ovr_a); end
    tick(2);
  endtask

  task automatic test_health;
    int g0;
    g0 = got_a; rdy_a = 1'b1; mask_a = 1'b0;
    repeat (3) q_a.push_back(8'h00);
    for (int n = 0; n <= 50; n++) begin
      @(negedge clk);
      osc[0] = 1'($urandom);
      en_a   = (n >= 2);
      #3;
      if (n == 34) begin
        n_cmp++; if (hf_a !== 1'b0) begin n_err++; $display("FAIL health_early: got %b expected 0", hf_a); end
      end
      if (n == 35) begin
        n_cmp++; if (hf_a !== 1'b1) begin n_err++; $display("FAIL health_trip: got %b expected 1", hf_a); end
      end
      if (n >= 35) begin
        n_cmp++; if (val_a !== 1'b0) begin n_err++; $display("FAIL health_block_%0d: got %b expected 0", n, val_a); end
      end
    end
    n_cmp++; if (got_a - g0 !== 3) begin n_err++; $display("FAIL health_words: got %0d expected 3", got_a - g0); end
    @(negedge clk); en_a = 1'b0; osc[0] = 1'b0;
    @(negedge clk); #3;
    n_cmp++; if (hf_a !== 1'b0) begin n_err++; $display("FAIL health_clear: got %b expected 0", hf_a); end
    mask_a = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid;
    int g0;
    rdy_a = 1'b0; mask_a = 1'b1;
    drive_a(8'hC3, 1'b0);
    #3;
    n_cmp++; if (val_a !== 1'b1 || data_a !== 8'hC3) begin n_err++; $display("FAIL pre_reset: got %b/%h expected 1/c3", val_a, data_a); end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk); osc[0] = 1'b1; en_a = 1'b1;
    end
    @(negedge clk); #2 reset_n = 1'b0; #1;
    n_cmp++; if ({val_a, ovr_a, hf_a, data_a} !== 11'd0) begin n_err++; $display("FAIL async_reset: got %b expected 0", {val_a, ovr_a, hf_a, data_a}); end
    @(negedge clk); reset_n = 1'b1; en_a = 1'b0; osc[0] = 1'b0;
    tick(2);
    g0 = got_a; rdy_a = 1'b1;
    drive_a(8'h96, 1'b1);
    tick(3); #3;
    n_cmp++; if (got_a - g0 !== 1) begin n_err++; $display("FAIL fresh_pulses: got %0d expected 1", got_a - g0); end
    n_cmp++; if (q_a.size() !== 0) begin n_err++; $display("FAIL fresh_pending: got %0d expected 0", q_a.size()); end
  endtask

  task automatic test_debias;
    logic s[30];
    logic [9:0] pat;
    logic [7:0] w;
    int ne, g0;
    pat = 10'b0110001110;
    for (int i = 0; i < 30; i++) s[i] = pat[9 - (i % 10)];
    ne = 0; w = 8'h00;
    for (int i = 0; i < 30; i += 2) begin
      if (s[i] != s[i+1] && ne < 8) begin w = {w[6:0], s[i]}; ne++; end
    end
    q_b.push_back(w);
    g0 = got_b; rdy_b = 1'b1; mask_b = 4'b1011;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      osc  = (n < 30) ? (s[n] ? 4'b0110 : 4'b1101) : 4'b0000;
      en_b = (n >= 2);
    end
    @(negedge clk); en_b = 1'b0; osc = 4'b0000;
    tick(2); #3;
    n_cmp++; if (got_b - g0 !== 1) begin n_err++; $display("FAIL debias_words: got %0d expected 1", got_b - g0); end
    n_cmp++; if (q_b.size() !== 0) begin n_err++; $display("FAIL debias_pending: got %0d expected 0", q_b.size()); end
    n_cmp++; if (hf_b !== 1'b0 || ovr_b !== 1'b0) begin n_err++; $display("FAIL debias_flags: got %b%b expected 00", hf_b, ovr_b); end
  endtask

  // Each sample value is held for three clocks; words are back to back.
  task automatic test_back_to_back;
    logic [7:0] s;
    int g0;
    s = 8'b1010_0110;
    q_c.push_back(s[7:4]); q_c.push_back(s[3:0]);
    g0 = got_c; rdy_c = 1'b1; mask_c = 2'b11;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      osc[1:0] = (n / 3 < 8) ? (s[7 - n/3] ? 2'b01 : 2'b11) : 2'b00;
      en_c     = (n >= 2 && n <= 26);
      #3;
      if (n == 14) begin
        n_cmp++; if (val_c !== 1'b0) begin n_err++; $display("FAIL div_early: got %b expected 0", val_c); end
      end
      if (n == 15) begin
        n_cmp++; if (val_c !== 1'b1) begin n_err++; $display("FAIL div_first: got %b expected 1", val_c); end
      end
    end
    @(negedge clk); en_c = 1'b0; #3;
    n_cmp++; if (got_c - g0 !== 2) begin n_err++; $display("FAIL div_words: got %0d expected 2", got_c - g0); end
    n_cmp++; if (q_c.size() !== 0) begin n_err++; $display("FAIL div_pending: got %0d expected 0", q_c.size()); end
  endtask

  initial begin
    osc = 4'b0000;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    mask_a = 1'b1; mask_b = 4'b1111; mask_c = 2'b11;
    test_reset;
    test_word_a(8'hFF);
    test_word_a(8'hB2);
    test_overrun;
    test_health;
    test_reset_mid;
    test_debias;
    test_back_to_back;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
